// File: rtl/pic_pkg.sv
// Shared types, OCW2 command codes and priority helpers for the 8259 service controller.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} pic_state_t;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_S_EOI        = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } pick_t;

  // Rank 0 is the highest priority; under rotation the line after last is rank 0.
  function automatic logic [2:0] priority_rank(input logic [2:0] id, input logic rot_en,
                                               input logic [2:0] last);
    return rot_en ? 3'(id - last - 3'd1) : id;
  endfunction

  function automatic pick_t highest_isr(input logic [NUM_IR-1:0] bits, input logic rot_en,
                                        input logic [2:0] last);
    pick_t      pick;
    logic [2:0] idx;
    pick = '0;
    // Scan from lowest priority upward so the highest-priority hit is written last.
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = rot_en ? 3'(last + 3'(k) + 3'd1) : 3'(k);
      if (bits[idx]) begin
        pick.valid = 1'b1;
        pick.id    = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pic_service_controller_if.sv
// Bus-side handshake between the 8259 bus/control logic and the service controller.
interface pic_service_controller_if;
  logic       inta_pulse;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] cmd_level;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_oe;

  modport master (
    output inta_pulse, cmd_valid, cmd_code, cmd_level,
    input  int_out, vector_out, vector_oe
  );

  modport slave (
    input  inta_pulse, cmd_valid, cmd_code, cmd_level,
    output int_out, vector_out, vector_oe
  );
endinterface

// File: rtl/Priority_Resolver.sv
// Combinational 8259 priority resolver: picks the best unmasked request and flags
// whether it outranks everything currently in service.
module Priority_Resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] IRQ_status,
  input  logic [NUM_IR-1:0] IS_status,
  input  logic [NUM_IR-1:0] IR_mask,
  input  logic              Rotating_priority,
  input  logic [2:0]        last_serviced,
  output logic [2:0]        PriorityID,
  output logic              INTFLAG
);

  pick_t req_pick;
  pick_t isr_pick;

  always_comb begin
    req_pick   = highest_isr(IRQ_status & ~IR_mask, Rotating_priority, last_serviced);
    isr_pick   = highest_isr(IS_status, Rotating_priority, last_serviced);
    PriorityID = req_pick.id;
    INTFLAG    = req_pick.valid &&
                 (!isr_pick.valid ||
                  (priority_rank(req_pick.id, Rotating_priority, last_serviced) <
                   priority_rank(isr_pick.id, Rotating_priority, last_serviced)));
  end

endmodule

// File: rtl/pic_service_controller.sv
// 8259 interrupt service sequencer: IRR/ISR ownership, two-pulse INTA acknowledge,
// vector generation and OCW2 EOI/rotate commands around the Priority_Resolver.
module pic_service_controller
  import pic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_pulse,
  input  logic                     level_trig,
  input  logic                     auto_eoi,
  input  logic [4:0]               vector_base,
  input  logic [NUM_IR-1:0]        imr,
  input  logic [NUM_IR-1:0]        ir_req,
  pic_service_controller_if.slave  bus,
  output logic [NUM_IR-1:0]        irr,
  output logic [NUM_IR-1:0]        isr
);

  pic_state_t        state, state_next;
  logic [NUM_IR-1:0] irr_next, isr_next, ir_prev;
  logic [2:0]        last_serviced, last_next;
  logic [2:0]        ack_id, ack_id_next;
  logic              rot_en, rot_en_next, rot_aeoi, rot_aeoi_next;
  logic              spurious, spurious_next, int_next;
  logic [2:0]        prio_id;
  logic              intflag;
  pick_t             eoi_pick;

  Priority_Resolver u_resolver (
    .IRQ_status        (irr),
    .IS_status         (isr),
    .IR_mask           (imr),
    .Rotating_priority (rot_en),
    .last_serviced     (last_serviced),
    .PriorityID        (prio_id),
    .INTFLAG           (intflag)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    isr_next       = isr;
    last_next      = last_serviced;
    rot_en_next    = rot_en;
    rot_aeoi_next  = rot_aeoi;
    ack_id_next    = ack_id;
    spurious_next  = spurious;
    int_next       = bus.int_out;
    bus.vector_oe  = 1'b0;
    bus.vector_out = '0;
    irr_next       = level_trig ? ir_req : ((irr & ir_req) | (ir_req & ~ir_prev));
    eoi_pick       = highest_isr(isr, rot_en, last_serviced);

    if (bus.cmd_valid) begin
      unique case (bus.cmd_code)
        OCW2_NS_EOI:       if (eoi_pick.valid) isr_next[eoi_pick.id] = 1'b0;
        OCW2_S_EOI:        isr_next[bus.cmd_level] = 1'b0;
        OCW2_ROT_NS_EOI:   if (eoi_pick.valid) begin
                             isr_next[eoi_pick.id] = 1'b0;
                             last_next             = eoi_pick.id;
                             rot_en_next           = 1'b1;
                           end
        OCW2_ROT_S_EOI:    if (isr != '0) begin
                             isr_next[bus.cmd_level] = 1'b0;
                             last_next               = bus.cmd_level;
                             rot_en_next             = 1'b1;
                           end
        OCW2_SET_PRIO:     begin
                             last_next   = bus.cmd_level;
                             rot_en_next = 1'b1;
                           end
        OCW2_ROT_AEOI_SET: rot_aeoi_next = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_aeoi_next = 1'b0;
        default:           ;
      endcase
    end

    // FSM updates follow the EOI so an ACK1 set of the same ISR bit wins.
    unique case (state)
      IDLE: begin
        int_next = intflag;
        if (bus.inta_pulse) begin
          state_next    = ACK1;
          ack_id_next   = prio_id;
          spurious_next = !intflag;
          int_next      = 1'b0;
          if (intflag) begin
            isr_next[prio_id] = 1'b1;
            if (!level_trig) irr_next[prio_id] = 1'b0;
          end
        end
      end
      ACK1: if (bus.inta_pulse) state_next = ACK2;
      ACK2: begin
        bus.vector_oe  = 1'b1;
        bus.vector_out = {vector_base, spurious ? 3'd7 : ack_id};
        if (auto_eoi && !spurious) begin
          isr_next[ack_id] = 1'b0;
          if (rot_aeoi) last_next = ack_id;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (init_pulse) begin
      state_next     = IDLE;
      irr_next       = '0;
      isr_next       = '0;
      last_next      = 3'd7;
      rot_en_next    = 1'b0;
      rot_aeoi_next  = 1'b0;
      ack_id_next    = '0;
      spurious_next  = 1'b0;
      int_next       = 1'b0;
      bus.vector_oe  = 1'b0;
      bus.vector_out = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      irr           <= '0;
      isr           <= '0;
      ir_prev       <= '0;
      last_serviced <= 3'd7;
      rot_en        <= 1'b0;
      rot_aeoi      <= 1'b0;
      ack_id        <= '0;
      spurious      <= 1'b0;
      bus.int_out   <= 1'b0;
    end else begin
      state         <= state_next;
      irr           <= irr_next;
      isr           <= isr_next;
      ir_prev       <= ir_req;
      last_serviced <= last_next;
      rot_en        <= rot_en_next;
      rot_aeoi      <= rot_aeoi_next;
      ack_id        <= ack_id_next;
      spurious      <= spurious_next;
      bus.int_out   <= int_next;
    end
  end

endmodule

// File: tb/tb_pic_service_controller.sv
// Directed-vector bench for pic_service_controller with hand-computed expectations.
module tb_pic_service_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_pulse = 1'b0;
  logic       level_trig = 1'b0;
  logic       auto_eoi = 1'b0;
  logic [4:0] vector_base = 5'h08;
  logic [7:0] imr = 8'h00;
  logic [7:0] ir_req = 8'h00;
  logic [7:0] irr, isr;
  int         n_vec = 0;
  int         n_err = 0;

  pic_service_controller_if bus ();

  pic_service_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_pulse  (init_pulse),
    .level_trig  (level_trig),
    .auto_eoi    (auto_eoi),
    .vector_base (vector_base),
    .imr         (imr),
    .ir_req      (ir_req),
    .bus         (bus),
    .irr         (irr),
    .isr         (isr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_inta();
    bus.inta_pulse = 1'b1;
    tick();
    bus.inta_pulse = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] code, input logic [2:0] lvl);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_level = lvl;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.inta_pulse = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_code   = 3'd0;
    bus.cmd_level  = 3'd0;
    tick(2);
    n_vec++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL reset_int got=%b exp=0", bus.int_out); end
    n_vec++; if (bus.vector_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", bus.vector_oe); end
    n_vec++; if (bus.vector_out !== 8'h00) begin n_err++; $display("FAIL reset_vec got=%h exp=00", bus.vector_out); end
    n_vec++; if ({irr, isr} !== 16'h0000) begin n_err++; $display("FAIL reset_regs got=%h exp=0000", {irr, isr}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_ack();
    ir_req[1] = 1'b1;
    tick();
    n_vec++; if (irr !== 8'h02) begin n_err++; $display("FAIL basic_irr got=%h exp=02", irr); end
    n_vec++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL basic_int_early got=%b exp=0", bus.int_out); end
    tick();
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL basic_int got=%b exp=1", bus.int_out); end
    pulse_inta();
    n_vec++; if (isr !== 8'h02) begin n_err++; $display("FAIL basic_isr got=%h exp=02", isr); end
    n_vec++; if (irr !== 8'h00) begin n_err++; $display("FAIL basic_irr_clr got=%h exp=00", irr); end
    n_vec++; if ({bus.int_out, bus.vector_oe} !== 2'b00) begin n_err++; $display("FAIL basic_ack1 got=%b exp=00", {bus.int_out, bus.vector_oe}); end
    ir_req[1] = 1'b0;
    pulse_inta();
    n_vec++; if (bus.vector_oe !== 1'b1) begin n_err++; $display("FAIL basic_oe got=%b exp=1", bus.vector_oe); end
    n_vec++; if (bus.vector_out !== 8'h41) begin n_err++; $display("FAIL basic_vec got=%h exp=41", bus.vector_out); end
    tick();
    n_vec++; if (bus.vector_oe !== 1'b0) begin n_err++; $display("FAIL basic_oe_end got=%b exp=0", bus.vector_oe); end
    n_vec++; if (isr !== 8'h02) begin n_err++; $display("FAIL basic_isr_hold got=%h exp=02", isr); end
  endtask

  task automatic test_nesting();
    ir_req[3] = 1'b1;
    tick(2);
    n_vec++; if (irr !== 8'h08) begin n_err++; $display("FAIL nest_irr got=%h exp=08", irr); end
    n_vec++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL nest_blocked got=%b exp=0", bus.int_out); end
    ir_req[0] = 1'b1;
    tick(2);
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL nest_int got=%b exp=1", bus.int_out); end
    pulse_inta();
    n_vec++; if (isr !== 8'h03) begin n_err++; $display("FAIL nest_isr got=%h exp=03", isr); end
    pulse_inta();
    n_vec++; if (bus.vector_out !== 8'h40) begin n_err++; $display("FAIL nest_vec got=%h exp=40", bus.vector_out); end
    tick();
    send_cmd(3'b001, 3'd0);
    n_vec++; if (isr !== 8'h02) begin n_err++; $display("FAIL nest_ns_eoi got=%h exp=02", isr); end
    ir_req = 8'h00;
    tick();
    n_vec++; if (irr !== 8'h00) begin n_err++; $display("FAIL nest_irr_fall got=%h exp=00", irr); end
    send_cmd(3'b011, 3'd1);
    n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL nest_s_eoi got=%h exp=00", isr); end
  endtask

  task automatic test_rotation();
    send_cmd(3'b110, 3'd0);
    ir_req[7:6] = 2'b11;
    tick();
    n_vec++; if (irr !== 8'hC0) begin n_err++; $display("FAIL rot_irr got=%h exp=c0", irr); end
    tick();
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL rot_int got=%b exp=1", bus.int_out); end
    pulse_inta();
    n_vec++; if ({irr, isr} !== 16'h8040) begin n_err++; $display("FAIL rot_ack1 got=%h exp=8040", {irr, isr}); end
    pulse_inta();
    n_vec++; if (bus.vector_out !== 8'h46) begin n_err++; $display("FAIL rot_vec6 got=%h exp=46", bus.vector_out); end
    tick(2);
    n_vec++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL rot_blocked got=%b exp=0", bus.int_out); end
    send_cmd(3'b111, 3'd6);
    n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL rot_s_eoi got=%h exp=00", isr); end
    tick();
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL rot_int7 got=%b exp=1", bus.int_out); end
    pulse_inta();
    pulse_inta();
    n_vec++; if (bus.vector_out !== 8'h47) begin n_err++; $display("FAIL rot_vec7 got=%h exp=47", bus.vector_out); end
    tick();
    send_cmd(3'b011, 3'd7);
    ir_req = 8'h00;
    tick();
    n_vec++; if ({irr, isr} !== 16'h0000) begin n_err++; $display("FAIL rot_clean got=%h exp=0000", {irr, isr}); end
  endtask

  task automatic test_aeoi_rotate();
    auto_eoi = 1'b1;
    send_cmd(3'b100, 3'd0);
    ir_req[4] = 1'b1;
    tick(2);
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL aeoi_int got=%b exp=1", bus.int_out); end
    pulse_inta();
    n_vec++; if (isr !== 8'h10) begin n_err++; $display("FAIL aeoi_isr got=%h exp=10", isr); end
    pulse_inta();
    n_vec++; if ({bus.vector_oe, bus.vector_out} !== 9'h144) begin n_err++; $display("FAIL aeoi_vec got=%h exp=144", {bus.vector_oe, bus.vector_out}); end
    tick();
    n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL aeoi_clear got=%h exp=00", isr); end
    ir_req = 8'h00;
    tick();
    // last_serviced=4 makes IR5 outrank IR3.
    ir_req = 8'h28;
    tick(2);
    pulse_inta();
    n_vec++; if (isr !== 8'h20) begin n_err++; $display("FAIL aeoi_rot_isr got=%h exp=20", isr); end
    pulse_inta();
    n_vec++; if (bus.vector_out !== 8'h45) begin n_err++; $display("FAIL aeoi_rot_vec got=%h exp=45", bus.vector_out); end
    tick();
    ir_req = 8'h00;
    tick(2);
    n_vec++; if ({bus.int_out, irr, isr} !== 17'h0) begin n_err++; $display("FAIL aeoi_idle got=%h exp=00000", {bus.int_out, irr, isr}); end
    auto_eoi = 1'b0;
    send_cmd(3'b000, 3'd0);
  endtask

  task automatic test_mask();
    imr = 8'h01;
    ir_req[0] = 1'b1;
    tick(2);
    n_vec++; if (irr !== 8'h01) begin n_err++; $display("FAIL mask_irr got=%h exp=01", irr); end
    n_vec++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL mask_int got=%b exp=0", bus.int_out); end
    imr = 8'h00;
    tick();
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL unmask_int got=%b exp=1", bus.int_out); end
    ir_req = 8'h00;
    tick(2);
    n_vec++; if ({bus.int_out, irr} !== 9'h000) begin n_err++; $display("FAIL mask_clean got=%h exp=000", {bus.int_out, irr}); end
  endtask

  task automatic test_spurious();
    ir_req[2] = 1'b1;
    tick(2);
    n_vec++; if ({bus.int_out, irr} !== 9'h104) begin n_err++; $display("FAIL spur_req got=%h exp=104", {bus.int_out, irr}); end
    ir_req[2] = 1'b0;
    tick(2);
    n_vec++; if ({bus.int_out, irr} !== 9'h000) begin n_err++; $display("FAIL spur_drop got=%h exp=000", {bus.int_out, irr}); end
    pulse_inta();
    n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL spur_isr got=%h exp=00", isr); end
    pulse_inta();
    n_vec++; if ({bus.vector_oe, bus.vector_out} !== 9'h147) begin n_err++; $display("FAIL spur_vec got=%h exp=147", {bus.vector_oe, bus.vector_out}); end
    tick();
    n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL spur_isr_end got=%h exp=00", isr); end
  endtask

  task automatic test_reset_init();
    ir_req[1] = 1'b1;
    tick(2);
    pulse_inta();
    n_vec++; if (isr !== 8'h02) begin n_err++; $display("FAIL rst_pre_isr got=%h exp=02", isr); end
    ir_req = 8'h00;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.int_out, bus.vector_oe, bus.vector_out, irr, isr} !== 26'h0) begin
      n_err++; $display("FAIL rst_async got=%h exp=0", {bus.int_out, bus.vector_oe, bus.vector_out, irr, isr});
    end
    tick();
    rst_n = 1'b1;
    tick();
    ir_req[5] = 1'b1;
    tick(2);
    n_vec++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL init_pre_int got=%b exp=1", bus.int_out); end
    pulse_inta();
    n_vec++; if (isr !== 8'h20) begin n_err++; $display("FAIL init_pre_isr got=%h exp=20", isr); end
    init_pulse = 1'b1;
    bus.inta_pulse = 1'b1;
    tick();
    init_pulse = 1'b0;
    bus.inta_pulse = 1'b0;
    n_vec++; if ({bus.vector_oe, bus.int_out, irr, isr} !== 18'h0) begin
      n_err++; $display("FAIL init_abort got=%h exp=0", {bus.vector_oe, bus.int_out, irr, isr});
    end
    pulse_inta();
    n_vec++; if (bus.vector_oe !== 1'b0) begin n_err++; $display("FAIL init_idle_oe got=%b exp=0", bus.vector_oe); end
    pulse_inta();
    n_vec++; if ({bus.vector_oe, bus.vector_out} !== 9'h147) begin n_err++; $display("FAIL init_vec got=%h exp=147", {bus.vector_oe, bus.vector_out}); end
    tick();
    ir_req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nesting();
    test_rotation();
    test_aeoi_rotate();
    test_mask();
    test_spurious();
    test_reset_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
